// File: rtl/dds_pkg.sv
// dds_pkg: shared state enum, default widths and example frequency words for the DDS sweep slice
package dds_pkg;
  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  localparam int FW_DEF = 32;
  localparam int PW_DEF = 8;
  localparam int DW_DEF = 24;
  localparam logic [31:0] F_2M = 32'd107374182;
  localparam logic [31:0] F_40M = 32'h8000_0000;
endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: reloadable down-counter that flags expiry when it reaches zero
module dds_dwell_timer import dds_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          reload,
  input  logic [DW-1:0] load_val,
  output logic          expired
);
  logic [DW-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (reload) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - DW'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency sweep of the DDS frequency word with dwell, single/continuous modes
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter int FW = FW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_pword,
  input  logic          cfg_cont,
  output logic [FW-1:0] fword,
  output logic [PW-1:0] pword,
  output logic          busy,
  output logic          step_stb,
  output logic          done
);
  state_t state;
  logic [FW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell, load_val;
  logic sh_cont, go, adv, expired, reload;
  logic [FW:0] nxt;
  // D-1 with dwell 0 treated as 1; the carry bit of nxt blocks any modulo wrap
  always_comb begin
    nxt = {1'b0, fword} + {1'b0, sh_step};
    adv = sh_step != '0 && !nxt[FW] && nxt[FW-1:0] <= sh_stop;
    go = state == IDLE && start && !abort;
    load_val = go ? cfg_dwell - DW'(cfg_dwell != '0) : sh_dwell - DW'(sh_dwell != '0);
    reload = go || (state == DWELL && !abort && expired && (adv || sh_cont));
  end
  dds_dwell_timer #(.DW(DW)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .reload(reload),
    .load_val(load_val),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      fword <= '0;
      pword <= '0;
      busy <= 1'b0;
      step_stb <= 1'b0;
      done <= 1'b0;
      sh_start <= '0;
      sh_stop <= '0;
      sh_step <= '0;
      sh_dwell <= '0;
      sh_cont <= 1'b0;
    end else begin
      step_stb <= reload;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
      end else case (state)
        IDLE: if (start) begin
          sh_start <= cfg_f_start;
          sh_stop <= cfg_f_stop;
          sh_step <= cfg_f_step;
          sh_dwell <= cfg_dwell;
          sh_cont <= cfg_cont;
          fword <= cfg_f_start;
          pword <= cfg_pword;
          busy <= 1'b1;
          state <= DWELL;
        end
        DWELL: if (expired) begin
          if (adv) fword <= nxt[FW-1:0];
          else if (sh_cont) fword <= sh_start;
          else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Linear frequency-sweep controller that sits directly upstream of the DDS core and drives its frequency and phase words. On a start pulse it latches a sweep configuration, then steps the frequency word from a start value to a stop value in fixed increments, holding each value for a programmable number of clocks. It supports single-shot and continuous (wrap-around) modes and reports busy, done and per-step strobes for downstream capture logic.

## Interface
- FW, 32, frequency-word width; must match the DDS phase accumulator.
- PW, 8, phase-word width.
- DW, 24, dwell-counter width.
- clk  in  1  system clock, same domain as the DDS core.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  stop the sweep; takes effect at the next edge from any state.
- cfg_f_start  in  FW  first frequency word.
- cfg_f_stop  in  FW  last allowed frequency word, inclusive.
- cfg_f_step  in  FW  increment, unsigned.
- cfg_dwell  in  DW  clocks per frequency; 0 is treated as 1.
- cfg_pword  in  PW  phase offset, passed through at start.
- cfg_cont  in  1  1 = continuous wrap, 0 = single sweep.
- fword  out  FW  frequency word to the DDS core; registered.
- pword  out  PW  phase word to the DDS core; registered.
- busy  out  1  high while a sweep is active.
- step_stb  out  1  one-cycle pulse each time fword takes a new sweep value.
- done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- States are IDLE, DWELL and DONE.
- IDLE:
  - On start with abort low: latch all cfg_* into shadow registers, set fword to cfg_f_start and pword to cfg_pword.
  - Load cnt with D−1, where D = max(cfg_dwell, 1). Assert step_stb and busy, then go to DWELL.
  - cfg_* changes after the latch have no effect until the next start.
- DWELL:
  - While cnt ≠ 0, decrement cnt.
  - When cnt = 0, form nxt = fword + step at FW+1 bits.
  - If step ≠ 0, the carry is 0 and nxt ≤ f_stop: fword ← nxt[FW−1:0], cnt ← D−1, step_stb pulses.
  - Otherwise the sweep end is reached:
    - If cont = 1: fword ← f_start, cnt ← D−1, step_stb pulses, stay in DWELL.
    - If cont = 0: go to DONE, busy ← 0, done pulses, fword holds its last value.
- DONE: transient single cycle; returns to IDLE at the next edge. A start arriving in this cycle is ignored.
- abort:
  - From any state the next state is IDLE with busy ← 0.
  - done and step_stb are not asserted; fword and pword hold.
  - abort wins over a simultaneous start or sweep end.
- start while busy is ignored.
- Boundary cases:
  - f_start > f_stop gives exactly one dwell at f_start.
  - step = 0 gives one dwell at f_start (single mode), or f_start held indefinitely with a step_stb every D cycles (continuous mode).
  - fword never exceeds f_stop and never wraps modulo 2^FW.

## Timing
- Reset values: fword = 0, pword = 0, busy = 0, step_stb = 0, done = 0, cnt = 0, state IDLE.
- start sampled at edge k: fword = f_start, busy = 1 and step_stb = 1 are all visible after edge k.
- Each sweep value is held for exactly D clocks. step_stb is coincident with the fword change.
- Single sweep of N values: busy is high for exactly N·D cycles. done is asserted during the cycle after busy falls, and busy and done are never high together.
- Reset asserted mid-sweep forces reset values immediately (asynchronous). Release is synchronous to clk.

## Structure
- Shared package dds_pkg holds:
  - the state enum (IDLE, DWELL, DONE);
  - default widths FW_DEF = 32, PW_DEF = 8, DW_DEF = 24;
  - the named example words F_2M = 32'd107374182 and F_40M = 32'h80000000.
- One sub-module, dds_dwell_timer: reload input, D−1 load value, expiry output, DW-bit down-counter. The next-value compare stays in the top FSM.

## Test plan
- Reset mid-sweep, with rstn low for 3 cycles during a dwell: all outputs go to 0 immediately and the FSM is in IDLE after release.
- Basic sweep, with start=100, stop=130, step=10, dwell=4, cont=0: fword sequence 100/110/120/130, 4 cycles each, 4 step_stb pulses, busy high 16 cycles, one done pulse.
- Carry, with start=32'hFFFF_FFF0, stop=32'hFFFF_FFFF, step=16, dwell=0: one 1-cycle dwell at FFFF_FFF0, then done; fword never wraps.
- Continuous mode, with start=0, stop=20, step=10, dwell=2, cont=1: sequence 0,10,20,0,10,… with no done; abort during a dwell on 10 leaves fword=10 and drops busy with no done.
- Start handling:
  - start during busy is ignored;
  - start and abort in the same IDLE cycle does not begin a sweep;
  - cfg_f_stop changed mid-sweep does not alter the running sweep.
- Degenerate inputs:
  - step=0 with cont=0 gives one dwell then done;
  - f_start=50 with f_stop=40 gives one dwell at 50 then done;
  - cfg_pword=8'hA5 appears on pword after the start edge.
